// File: rtl/fp_add_sequencer.sv
// Operand FIFO and registered result stage around an external combinational FP adder.
// Define FP_ADD_SEQ_STICKY_FLAGS_EN to add the sticky exception flags with flags_clr.
module fp_add_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_add_sub_not,
    output logic [31:0]      fa_a,
    output logic [31:0]      fa_b,
    output logic             fa_add_sub_not,
    input  logic [31:0]      fa_result,
    input  logic             fa_underflow,
    input  logic             fa_overflow,
    input  logic             fa_inexact,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_underflow,
    output logic             out_overflow,
    output logic             out_inexact,
`ifdef FP_ADD_SEQ_STICKY_FLAGS_EN
    input  logic             flags_clr,
    output logic             sticky_underflow,
    output logic             sticky_overflow,
    output logic             sticky_inexact,
`endif
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    localparam int DATA_W = 32;
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    logic [DATA_W-1:0] a_mem  [DEPTH];
    logic [DATA_W-1:0] b_mem  [DEPTH];
    logic              op_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;

    logic              push;
    logic              pop;
    logic              deliver;
    logic              fifo_nonempty;

    out_state_t        state_q;
    out_state_t        state_d;

    logic              vld_p1;
    logic [DATA_W-1:0] result_p1;
    logic              underflow_p1;
    logic              overflow_p1;
    logic              inexact_p1;
    logic [CNT_W-1:0]  op_count_q;

    assign fifo_nonempty = (count != '0);
    assign in_ready      = (count < DEPTH_C);
    assign push          = in_valid & in_ready;
    assign pop           = fifo_nonempty & ((state_q == OUT_EMPTY) | out_ready);
    assign vld_p1        = (state_q == OUT_FULL);
    assign deliver       = vld_p1 & out_ready;

    // ---- stage p0: operand FIFO ----
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wr_ptr]  <= in_a;
            b_mem[wr_ptr]  <= in_b;
            op_mem[wr_ptr] <= in_add_sub_not;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // An empty FIFO presents 0 + 0 so the adder outputs settle to a known value.
    always_comb begin
        fa_a           = '0;
        fa_b           = '0;
        fa_add_sub_not = 1'b1;
        if (fifo_nonempty) begin
            fa_a           = a_mem[rd_ptr];
            fa_b           = b_mem[rd_ptr];
            fa_add_sub_not = op_mem[rd_ptr];
        end
    end

    // ---- stage p1: result register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            OUT_EMPTY: begin
                if (pop) begin
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (out_ready && !pop) begin
                    state_d = OUT_EMPTY;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_p1    <= '0;
            underflow_p1 <= 1'b0;
            overflow_p1  <= 1'b0;
            inexact_p1   <= 1'b0;
        end else if (pop) begin
            result_p1    <= fa_result;
            underflow_p1 <= fa_underflow;
            overflow_p1  <= fa_overflow;
            inexact_p1   <= fa_inexact;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q <= '0;
        end else if (deliver) begin
            op_count_q <= op_count_q + CNT_W'(1);
        end
    end

`ifdef FP_ADD_SEQ_STICKY_FLAGS_EN
    logic sticky_uf_q;
    logic sticky_ov_q;
    logic sticky_nx_q;

    // A delivery in the same cycle as a clear still records its flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_uf_q <= 1'b0;
            sticky_ov_q <= 1'b0;
            sticky_nx_q <= 1'b0;
        end else begin
            sticky_uf_q <= (sticky_uf_q & ~flags_clr) | (deliver & underflow_p1);
            sticky_ov_q <= (sticky_ov_q & ~flags_clr) | (deliver & overflow_p1);
            sticky_nx_q <= (sticky_nx_q & ~flags_clr) | (deliver & inexact_p1);
        end
    end

    assign sticky_underflow = sticky_uf_q;
    assign sticky_overflow  = sticky_ov_q;
    assign sticky_inexact   = sticky_nx_q;
`endif

    assign out_valid     = vld_p1;
    assign out_result    = result_p1;
    assign out_underflow = underflow_p1;
    assign out_overflow  = overflow_p1;
    assign out_inexact   = inexact_p1;
    assign busy          = fifo_nonempty | vld_p1;
    assign op_count      = op_count_q;

endmodule

// File: tb/tb_fp_add_sequencer.sv
// Directed bench for fp_add_sequencer with a stub adder and an in-order result scoreboard.
// Also covers the sticky flags when FP_ADD_SEQ_STICKY_FLAGS_EN is defined.
module tb_fp_add_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_add_sub_not;
    logic [31:0] fa_a;
    logic [31:0] fa_b;
    logic        fa_add_sub_not;
    logic [31:0] fa_result;
    logic        fa_underflow;
    logic        fa_overflow;
    logic        fa_inexact;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_underflow;
    logic        out_overflow;
    logic        out_inexact;
    logic        busy;
    logic [3:0]  op_count;
`ifdef FP_ADD_SEQ_STICKY_FLAGS_EN
    logic        flags_clr;
    logic        sticky_underflow;
    logic        sticky_overflow;
    logic        sticky_inexact;
`endif

    int          checks   = 0;
    int          failures = 0;
    int          n_push   = 0;
    int          n_deliv  = 0;
    logic [34:0] cur_exp;
    logic [34:0] exp_q[$];
    logic        hold_prev = 1'b0;
    logic [34:0] held;

    always #5 clk = ~clk;

    fp_add_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_add_sub_not (in_add_sub_not),
        .fa_a           (fa_a),
        .fa_b           (fa_b),
        .fa_add_sub_not (fa_add_sub_not),
        .fa_result      (fa_result),
        .fa_underflow   (fa_underflow),
        .fa_overflow    (fa_overflow),
        .fa_inexact     (fa_inexact),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_underflow  (out_underflow),
        .out_overflow   (out_overflow),
        .out_inexact    (out_inexact),
`ifdef FP_ADD_SEQ_STICKY_FLAGS_EN
        .flags_clr        (flags_clr),
        .sticky_underflow (sticky_underflow),
        .sticky_overflow  (sticky_overflow),
        .sticky_inexact   (sticky_inexact),
`endif
        .busy           (busy),
        .op_count       (op_count)
    );

    // Stub adder: exact answers for the directed cases, an arbitrary mix otherwise.
    function automatic logic [34:0] fa_model(input logic [31:0] a, input logic [31:0] b, input logic op);
        if (op && a == 32'h3F800000 && b == 32'h40000000) return {32'h40400000, 3'b000};
        if (!op && a == b) return {32'h00000000, 3'b000};
        if (op && a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) return {32'h7F800000, 3'b011};
        return {a + b + {31'b0, op}, a[0] & b[0], a[1] ^ b[1], a[2] | b[2]};
    endfunction

    logic [34:0] fa_out;
    assign fa_out = fa_model(fa_a, fa_b, fa_add_sub_not);
    assign {fa_result, fa_underflow, fa_overflow, fa_inexact} = fa_out;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Inputs only change just after the rising edge, so at the falling edge they
    // show exactly the handshakes of the coming edge.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (hold_prev) begin
                chk("hold", {out_valid, out_result, out_underflow, out_overflow, out_inexact},
                    {1'b1, held});
            end
            hold_prev = out_valid && !out_ready;
            held      = {out_result, out_underflow, out_overflow, out_inexact};
            if (in_valid && in_ready) begin
                exp_q.push_back(cur_exp);
                n_push++;
            end
            if (out_valid && out_ready) begin
                chk("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("result", {out_result, out_underflow, out_overflow, out_inexact},
                        exp_q.pop_front());
                end
                n_deliv++;
            end
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [34:0] e);
        in_valid = 1'b1; in_a = a; in_b = b; in_add_sub_not = op; cur_exp = e;
        tick;
        in_valid = 1'b0;
        chk({tag, "_fa_a"}, fa_a, a);
        chk({tag, "_fa_b"}, fa_b, b);
        chk({tag, "_fa_op"}, fa_add_sub_not, op);
        chk({tag, "_vld_early"}, out_valid, 1'b0);
        tick;
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_out"}, {out_result, out_underflow, out_overflow, out_inexact}, e);
        chk({tag, "_fa_idle"}, {fa_a, fa_b, fa_add_sub_not}, {64'h0, 1'b1});
        tick;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_a = '0; in_b = '0; in_add_sub_not = 1'b1; cur_exp = '0;
`ifdef FP_ADD_SEQ_STICKY_FLAGS_EN
        flags_clr = 1'b0;
`endif
        tick; tick;
        chk("rst_out", {out_valid, out_result, out_underflow, out_overflow, out_inexact}, 36'h0);
        chk("rst_cnt", op_count, 4'd0);
        chk("rst_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fa", {fa_a, fa_b, fa_add_sub_not}, {64'h0, 1'b1});
        rst_n = 1'b1;
        tick;

        out_ready = 1'b1;
        single("add", 32'h3F800000, 32'h40000000, 1'b1, {32'h40400000, 3'b000});
        chk("add_cnt", op_count, 4'd1);
        chk("add_busy", busy, 1'b0);
        single("sub", 32'h3F800000, 32'h3F800000, 1'b0, {32'h00000000, 3'b000});
        single("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b1, {32'h7F800000, 3'b011});
        chk("ovf_cnt", op_count, 4'd3);
`ifdef FP_ADD_SEQ_STICKY_FLAGS_EN
        chk("sticky_set", {sticky_underflow, sticky_overflow, sticky_inexact}, 3'b011);
        flags_clr = 1'b1;
        tick;
        flags_clr = 1'b0;
        chk("sticky_clr", {sticky_underflow, sticky_overflow, sticky_inexact}, 3'b000);
`endif

        // Backpressure: 7 offered, DEPTH+1 taken.
        out_ready = 1'b0;
        begin
            int acc = 0;
            for (int i = 0; i < 7; i++) begin
                in_valid = 1'b1;
                in_a = 32'h10000000 + 32'(i); in_b = 32'(i * 3); in_add_sub_not = i[0];
                cur_exp = fa_model(in_a, in_b, in_add_sub_not);
                if (in_ready) acc++;
                tick;
            end
            in_valid = 1'b0;
            chk("bp_accepted", 64'(acc), 64'd5);
        end
        chk("bp_ready_low", in_ready, 1'b0);
        chk("bp_busy", busy, 1'b1);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_stream_vld", out_valid, 1'b1);
            tick;
        end
        chk("bp_drained", {out_valid, busy}, 2'b00);
        chk("bp_cnt", op_count, 4'd8);
        chk("bp_sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-stream with three pairs queued.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'h20000000 + 32'(i); in_b = 32'h5; in_add_sub_not = 1'b1;
            cur_exp = fa_model(in_a, in_b, in_add_sub_not);
            tick;
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_vld", out_valid, 1'b0);
        chk("mid_rst_ready", in_ready, 1'b1);
        chk("mid_rst_cnt", op_count, 4'd0);
        tick;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("post_rst_quiet", {out_valid, busy}, 2'b00);
        end

        // Wrap: 17 deliveries through a 4-bit counter under random backpressure.
        n_push = 0; n_deliv = 0;
        for (int cyc = 0; cyc < 2000 && n_deliv < 17; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            if (n_push < 17 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
                in_add_sub_not = 1'($urandom_range(0, 1));
                cur_exp = fa_model(in_a, in_b, in_add_sub_not);
            end else begin
                in_valid = 1'b0;
            end
            tick;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
        chk("wrap_delivered", 64'(n_deliv), 64'd17);
        chk("wrap_cnt", op_count, 4'd1);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);
        chk("wrap_idle", {out_valid, busy}, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_add_sequencer.md
Name: fp_add_sequencer

Overview:
- Sequential front/back-end for the combinational FP_Adder: buffers operand pairs, presents them to the adder, and registers result plus exception flags.
- Upstream side is a valid/ready operand stream from the datapath controller.
- Downstream side is a valid/ready result stream.
- The adder is external: this block drives its a/b/add_sub_not inputs and samples its result/underflow/overflow/inexcat outputs in the same cycle.

Parameters:
- DEPTH, 4, operand FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  FIFO can accept.
- in_a  input  32  IEEE-754 single operand a.
- in_b  input  32  IEEE-754 single operand b.
- in_add_sub_not  input  1  1 = a+b, 0 = a-b.
- fa_a  output  32  to adder a.
- fa_b  output  32  to adder b.
- fa_add_sub_not  output  1  to adder add_sub_not.
- fa_result  input  32  from adder result.
- fa_underflow  input  1  from adder.
- fa_overflow  input  1  from adder.
- fa_inexact  input  1  from adder inexcat.
- out_valid  output  1  result register holds data.
- out_ready  input  1  consumer accepts.
- out_result  output  32  registered sum.
- out_underflow  output  1  flag registered with result.
- out_overflow  output  1  flag registered with result.
- out_inexact  output  1  flag registered with result.
- busy  output  1  FIFO non-empty or out_valid.
- op_count  output  CNT_W  results delivered (out_valid & out_ready), wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst_n low, async):
  - FIFO pointers and count = 0; out_valid = 0; out_result = 0; all out_* flags = 0; op_count = 0; state = OUT_EMPTY.
  - A reset mid-operation discards all buffered and in-flight entries; nothing is emitted after release.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = (count < DEPTH); no same-cycle bypass when full, even if a pop occurs that cycle.
  - Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
  - Push and pop in the same cycle leave count unchanged.
- Adder drive:
  - When count != 0: fa_a/fa_b/fa_add_sub_not = FIFO head, combinationally.
  - When count == 0: fa_a = 0, fa_b = 0, fa_add_sub_not = 1, which gives the adder a quiescent 0+0.
- Output register state machine:
  - OUT_EMPTY -> OUT_FULL on pop.
  - OUT_FULL -> OUT_EMPTY when out_ready & no pop.
  - OUT_FULL -> OUT_FULL when out_ready & pop, or when !out_ready.
- Pop rule: pop = (count != 0) & (state == OUT_EMPTY | out_ready).
  - On pop, the output register loads {fa_result, fa_underflow, fa_overflow, fa_inexact}.
  - out_valid = (state == OUT_FULL).
- Hold rule: while out_valid & !out_ready, all out_* are stable and no pop occurs.
- Latency:
  - With the pipeline idle, a pair accepted at edge k appears with out_valid high after edge k+1, i.e. 2 edges.
  - Steady-state throughput is 1 result per cycle with out_ready held high.
- Capacity: with out_ready = 0, DEPTH+1 pairs are accepted (DEPTH in the FIFO, 1 in the output register).
- Ordering: strictly in order; every accepted pair yields exactly one result.
- op_count increments on out_valid & out_ready and wraps from all-ones to 0.
- busy = (count != 0) | out_valid.

Optional Feature:
- FP_ADD_SEQ_STICKY_FLAGS_EN.
- When defined:
  - Adds input flags_clr (1) and outputs sticky_underflow, sticky_overflow, sticky_inexact (1 each).
  - Each sticky bit ORs in the corresponding flag of every delivered result (out_valid & out_ready).
  - flags_clr zeroes the sticky bits; if a clear and a delivery happen in the same cycle, the delivery's flags win and set the bit.
  - Sticky bits reset to 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Basic add: push a=0x3F800000, b=0x40000000, add_sub_not=1, out_ready=1 -> out_result=0x40400000, flags 0, out_valid rises 2 edges after accept, op_count=1.
- Subtract to zero: a=0x3F800000, b=0x3F800000, add_sub_not=0 -> out_result=0x00000000, flags 0.
- Overflow: a=b=0x7F7FFFFF, add -> out_overflow=1, out_result=0x7F800000. With FP_ADD_SEQ_STICKY_FLAGS_EN, sticky_overflow=1 until flags_clr.
- Backpressure (DEPTH=4): hold out_ready=0 and stream 7 pairs -> exactly 5 accepted, in_ready low afterwards. Then raise out_ready -> 5 results in push order on consecutive cycles, op_count=5, busy falls.
- Reset mid-stream: 3 pairs queued, pulse rst_n low asynchronously between edges -> out_valid=0, in_ready=1, op_count=0 immediately; no results emitted after release.
- Wrap: with CNT_W=4, deliver 17 results with out_ready toggling randomly -> op_count=1; FIFO pointers wrap with no loss or duplication.
